// File: rtl/apb_master_bridge.sv
// APB4 requester: turns valid/ready commands into IDLE/SETUP/ACCESS transfers
// and returns each result through a single-entry valid/ready response slot.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [STRB_WIDTH-1:0] PSTRB,
  output logic [2:0]            PPROT,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                slot_free;
  logic                accept;
  logic                complete;
  logic                abort_xfer;
  logic                wd_expired;
  logic [WD_WIDTH-1:0] wd_count;

  assign slot_free = !rsp_valid || rsp_ready;
  assign cmd_ready = slot_free &&
                     ((state == ST_IDLE) || ((state == ST_ACCESS) && PREADY));
  assign accept    = cmd_valid && cmd_ready;

  // wd_count holds the PREADY-low ACCESS cycles already seen, so the
  // TIMEOUT-th low cycle is the one that aborts.
  assign wd_expired = (TIMEOUT != 0) && (int'(wd_count) >= TIMEOUT - 1);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    abort_xfer = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A full response slot stalls the transfer in ACCESS until it drains.
        if (PREADY) begin
          if (slot_free) begin
            complete   = 1'b1;
            state_next = accept ? ST_SETUP : ST_IDLE;
          end
        end else if (wd_expired && slot_free) begin
          abort_xfer = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wd_count <= '0;
    end else if (accept) begin
      wd_count <= '0;
    end else if ((state == ST_ACCESS) && !PREADY && !wd_expired && (TIMEOUT != 0)) begin
      wd_count <= wd_count + 1'b1;
    end
  end

  // Request fields are captured on accept and then left alone, so they stay
  // stable through the whole transfer and keep their last value in IDLE.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      PSTRB   <= '0;
      PPROT   <= '0;
    end else begin
      PSEL    <= (state_next != ST_IDLE);
      PENABLE <= (state_next == ST_ACCESS);
      if (accept) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
        PSTRB  <= cmd_write ? cmd_strb : '0;
        PPROT  <= cmd_prot;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if (complete) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= PWRITE ? '0 : PRDATA;
      rsp_slverr  <= PSLVERR;
      rsp_timeout <= 1'b0;
    end else if (abort_xfer) begin
      rsp_valid   <= 1'b1;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b1;
      rsp_timeout <= 1'b1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
